// File: rtl/crc32_pkg.sv
// -----------------------------------------------------------------------------
// crc32_pkg
//   Shared constants and types for the CRC-32 frame checker.
//   CRC32_POLY  : generator polynomial, x^32 term implicit
//   CRC32_INIT  : remainder preload at frame start
//   CRC32_CHECK : remainder that marks a good frame (payload + CRC bytes)
//   state_e     : frame FSM states
// -----------------------------------------------------------------------------
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY  = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_CHECK = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/crc32_bit_engine.sv
// -----------------------------------------------------------------------------
// crc32_bit_engine
//   Bit-serial CRC-32 LFSR. One message bit is folded in per enabled cycle:
//     r <= {r[30:0], b} ^ (POLY & {32{r[31]}})
//   The message bit enters at the LSB (no x^32 pre-multiplication), so a
//   frame that carries its own CRC in the last 32 bits leaves a zero remainder.
// Ports
//   clk    : system clock
//   reset  : synchronous active-high reset, remainder -> INIT
//   init   : reload INIT (priority over en)
//   en     : shift one bit this cycle
//   bit_in : message bit
//   rem    : current remainder
// -----------------------------------------------------------------------------
module crc32_bit_engine
  import crc32_pkg::*;
#(
  parameter logic [31:0] POLY = CRC32_POLY,
  parameter logic [31:0] INIT = CRC32_INIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [31:0] rem
);

  logic [31:0] rem_q;
  logic [31:0] rem_d;

  always_comb begin
    rem_d = rem_q;
    if (init) begin
      rem_d = INIT;
    end else if (en) begin
      rem_d = {rem_q[30:0], bit_in} ^ (POLY & {32{rem_q[31]}});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= INIT;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign rem = rem_q;

endmodule

// File: rtl/crc32_frame_checker.sv
// -----------------------------------------------------------------------------
// crc32_frame_checker
//   Byte-stream front end for the bit-serial CRC-32 engine. Accepts frame
//   bytes (payload followed by 4 CRC bytes) over valid/ready, serialises each
//   byte into the LFSR one bit per clk, and reports a per-frame verdict.
//
// Ports
//   clk, reset  : single clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : byte input handshake, s_last on final byte
//   s_abort     : drop the current frame, no result produced
//   busy        : at least one byte accepted and no result yet
//   res_valid   : one-cycle result strobe, 9 cycles after the last handshake
//   res_ok      : remainder == CHECK_VALUE and length >= 4
//   res_crc     : final remainder (held until next res_valid)
//   res_len     : frame length in bytes, saturating (held until next res_valid)
//
// Build option CRC32_FRAME_STATS_EN:
//   adds input stats_clr and outputs good_cnt[15:0] / bad_cnt[15:0],
//   saturating counters of good and bad results; clear beats a coincident
//   result. Without the macro these ports do not exist.
// -----------------------------------------------------------------------------
module crc32_frame_checker
  import crc32_pkg::*;
#(
  parameter logic [31:0] POLY        = CRC32_POLY,
  parameter logic [31:0] INIT        = CRC32_INIT,
  parameter logic [31:0] CHECK_VALUE = CRC32_CHECK,
  parameter bit          LSB_FIRST   = 1'b0,
  parameter int          LEN_W       = 16      // must be >= 3 to hold the value 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic             s_abort,
  output logic             busy,
  output logic             res_valid,
  output logic             res_ok,
  output logic [31:0]      res_crc,
  output logic [LEN_W-1:0] res_len
`ifdef CRC32_FRAME_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      good_cnt,
  output logic [15:0]      bad_cnt
`endif
);

  state_e           state_q,     state_d;
  logic [7:0]       shreg_q,     shreg_d;
  logic             last_q,      last_d;
  logic [2:0]       bit_cnt_q,   bit_cnt_d;
  logic [LEN_W-1:0] len_q,       len_d;
  logic             res_valid_q, res_valid_d;
  logic             res_ok_q,    res_ok_d;
  logic [31:0]      res_crc_q,   res_crc_d;
  logic [LEN_W-1:0] res_len_q,   res_len_d;

  logic        hs;
  logic        eng_init;
  logic        eng_en;
  logic        eng_bit;
  logic [31:0] rem;

  // Ready in IDLE, or on the last bit of a non-final byte so a new byte can
  // be taken back-to-back (8 clk per byte).
  assign s_ready = (state_q == IDLE) ||
                   ((state_q == SHIFT) && (bit_cnt_q == 3'd7) && !last_q);

  // Abort drops any byte offered in the same cycle.
  assign hs = s_valid && s_ready && !s_abort;

  // The byte register is shifted each cycle, so the outgoing bit always sits
  // at one end of it.
  assign eng_bit = LSB_FIRST ? shreg_q[0] : shreg_q[7];

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    last_d      = last_q;
    bit_cnt_d   = bit_cnt_q;
    len_d       = len_q;
    res_valid_d = 1'b0;
    res_ok_d    = res_ok_q;
    res_crc_d   = res_crc_q;
    res_len_d   = res_len_q;
    eng_init    = 1'b0;
    eng_en      = 1'b0;

    if (hs && (len_q != {LEN_W{1'b1}})) begin
      len_d = len_q + LEN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d   = SHIFT;
          shreg_d   = s_data;
          last_d    = s_last;
          bit_cnt_d = 3'd0;
        end
      end

      SHIFT: begin
        eng_en    = 1'b1;
        shreg_d   = LSB_FIRST ? {1'b0, shreg_q[7:1]} : {shreg_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (last_q) begin
            state_d = DONE;
          end else if (hs) begin
            shreg_d   = s_data;
            last_d    = s_last;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DONE: begin
        // Last bit was shifted on the previous edge; capture and restart.
        res_valid_d = 1'b1;
        res_ok_d    = (rem == CHECK_VALUE) && (len_q >= LEN_W'(4));
        res_crc_d   = rem;
        res_len_d   = len_q;
        eng_init    = 1'b1;
        len_d       = '0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything above; result registers keep old values.
    if (s_abort) begin
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      len_d       = '0;
      eng_init    = 1'b1;
      eng_en      = 1'b0;
      res_valid_d = 1'b0;
      res_ok_d    = res_ok_q;
      res_crc_d   = res_crc_q;
      res_len_d   = res_len_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= 8'h00;
      last_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      len_q       <= '0;
      res_valid_q <= 1'b0;
      res_ok_q    <= 1'b0;
      res_crc_q   <= 32'h0;
      res_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      last_q      <= last_d;
      bit_cnt_q   <= bit_cnt_d;
      len_q       <= len_d;
      res_valid_q <= res_valid_d;
      res_ok_q    <= res_ok_d;
      res_crc_q   <= res_crc_d;
      res_len_q   <= res_len_d;
    end
  end

  crc32_bit_engine #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_engine (
    .clk    (clk),
    .reset  (reset),
    .init   (eng_init),
    .en     (eng_en),
    .bit_in (eng_bit),
    .rem    (rem)
  );

  // len_q only returns to zero on result, abort or reset, so it doubles as
  // the "frame open" flag between bytes.
  assign busy      = (state_q != IDLE) || (len_q != '0);
  assign res_valid = res_valid_q;
  assign res_ok    = res_ok_q;
  assign res_crc   = res_crc_q;
  assign res_len   = res_len_q;

`ifdef CRC32_FRAME_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q,  bad_cnt_d;

  // Counts follow the visible result strobe, so a clear in the strobe cycle
  // discards that result.
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (stats_clr) begin
      good_cnt_d = 16'h0;
      bad_cnt_d  = 16'h0;
    end else if (res_valid_q) begin
      if (res_ok_q) begin
        if (good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
      end else begin
        if (bad_cnt_q != 16'hFFFF) bad_cnt_d = bad_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      good_cnt_q <= 16'h0;
      bad_cnt_q  <= 16'h0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign good_cnt = good_cnt_q;
  assign bad_cnt  = bad_cnt_q;
`endif

endmodule

// File: tb/tb_crc32_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_crc32_frame_checker
//   Two DUT instances share one input stream: u_msb (LSB_FIRST=0) and
//   u_lsb (LSB_FIRST=1). Each frame is checked against a bit-serial reference
//   model in the matching bit order. Compile with +define+CRC32_FRAME_STATS_EN
//   to include the statistics counters.
// -----------------------------------------------------------------------------
module tb_crc32_frame_checker;
  import crc32_pkg::*;

  localparam int LEN_W = 16;
  localparam logic [127:0] DIGITS = "123456789";
  localparam logic [127:0] ABC    = "abc";

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_abort;

  logic        s_ready_m, busy_m, res_valid_m, res_ok_m;
  logic [31:0] res_crc_m;
  logic [15:0] res_len_m;
  logic        s_ready_l, busy_l, res_valid_l, res_ok_l;
  logic [31:0] res_crc_l;
  logic [15:0] res_len_l;
`ifdef CRC32_FRAME_STATS_EN
  logic        stats_clr;
  logic [15:0] good_m, bad_m, good_l, bad_l;
`endif

  always #5 clk = ~clk;

  crc32_frame_checker #(.LSB_FIRST(1'b0), .LEN_W(LEN_W)) u_msb (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_m),
    .s_data(s_data), .s_last(s_last), .s_abort(s_abort), .busy(busy_m),
    .res_valid(res_valid_m), .res_ok(res_ok_m), .res_crc(res_crc_m),
    .res_len(res_len_m)
`ifdef CRC32_FRAME_STATS_EN
    , .stats_clr(stats_clr), .good_cnt(good_m), .bad_cnt(bad_m)
`endif
  );

  crc32_frame_checker #(.LSB_FIRST(1'b1), .LEN_W(LEN_W)) u_lsb (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_l),
    .s_data(s_data), .s_last(s_last), .s_abort(s_abort), .busy(busy_l),
    .res_valid(res_valid_l), .res_ok(res_ok_l), .res_crc(res_crc_l),
    .res_len(res_len_l)
`ifdef CRC32_FRAME_STATS_EN
    , .stats_clr(stats_clr), .good_cnt(good_l), .bad_cnt(bad_l)
`endif
  );

  typedef struct {
    int           n;          // payload bytes
    logic [127:0] payload;    // right-aligned, first byte most significant
    int           crc_mode;   // 0 none, 1 append MSB-first CRC, 2 LSB-first CRC
    int           flip_idx;   // byte to corrupt after CRC generation, -1 none
    logic [7:0]   flip_mask;
    int           exp_len;
    bit           exp_ok_m;
    bit           exp_ok_l;
  } vec_t;

  vec_t        vecs [0:6];
  logic [7:0]  fb [0:19];
  int          fn;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_em;
  logic [31:0] last_el;
  int          last_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] r, input logic [7:0] b, input bit lsb);
    logic [31:0] x;
    logic        fbit;
    x = r;
    for (int i = 0; i < 8; i++) begin
      fbit = lsb ? b[i] : b[7-i];
      x = {x[30:0], fbit} ^ (x[31] ? CRC32_POLY : 32'h0);
    end
    return x;
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic build_frame(input vec_t v);
    logic [31:0] r;
    logic [7:0]  cb;
    bit          lsb;
    fn = 0;
    for (int i = 0; i < v.n; i++) begin
      fb[fn] = v.payload[8*(v.n-1-i) +: 8];
      fn++;
    end
    if (v.crc_mode != 0) begin
      lsb = (v.crc_mode == 2);
      r = CRC32_INIT;
      for (int i = 0; i < v.n; i++) r = crc_byte(r, fb[i], lsb);
      // Remainder of r*x^32: the CRC that zeroes the final remainder.
      for (int i = 0; i < 4; i++) r = crc_byte(r, 8'h00, lsb);
      for (int i = 0; i < 4; i++) begin
        cb = r[31-8*i -: 8];
        fb[fn] = lsb ? bitrev8(cb) : cb;
        fn++;
      end
    end
    if (v.flip_idx >= 0) fb[v.flip_idx] = fb[v.flip_idx] ^ v.flip_mask;
  endtask

  // Streams fb[0..fn-1]. stop_idx/action: after that byte's handshake, wait
  // until bit 3 then pulse abort (1) or reset (2). gap_idx: idle 12 cycles
  // after that byte.
  task automatic send_bytes(input int stop_idx, input int action, input int gap_idx);
    int c, prev, waitc;
    bit gap_ok;
    c = 0; prev = 0; gap_ok = 1'b1;
    for (int i = 0; i < fn; i++) begin
      s_valid = 1'b1; s_data = fb[i]; s_last = (i == fn - 1);
      waitc = 0;
      while (!s_ready_m && waitc < 40) begin
        @(negedge clk); c++; waitc++;
      end
      if (!s_ready_m) begin
        chk("ready_timeout", 32'd0, 32'd1);
        break;
      end
      if (i > 0 && (c - prev) != 8) gap_ok = 1'b0;
      prev = c;
      @(negedge clk); c++;
      if (i == 0) chk("busy_in_frame", {31'b0, busy_m}, 32'd1);
      if (i == stop_idx) begin
        s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        if (action == 1) s_abort = 1'b1;
        else reset = 1'b1;
        @(negedge clk);
        s_abort = 1'b0; reset = 1'b0;
        return;
      end
      if (i == gap_idx) begin
        s_valid = 1'b0;
        repeat (12) @(negedge clk);
        c += 12;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (gap_idx < 0 && fn > 1) chk("ready_gap_8", {31'b0, gap_ok}, 32'd1);
  endtask

  // Called at the negedge right after the last-byte handshake edge.
  task automatic wait_result(input string tag, input int exp_len, input bit ok_m, input bit ok_l);
    logic [31:0] em, el;
    int          k;
    logic        rdy_done;
    em = CRC32_INIT; el = CRC32_INIT;
    for (int i = 0; i < fn; i++) begin
      em = crc_byte(em, fb[i], 1'b0);
      el = crc_byte(el, fb[i], 1'b1);
    end
    k = 0; rdy_done = 1'b1;
    while (!res_valid_m && k < 20) begin
      @(negedge clk); k++;
      if (k == 8) rdy_done = s_ready_m;
    end
    chk({tag, "_latency"},  k, 9);
    chk({tag, "_ready_done"}, {31'b0, rdy_done}, 32'd0);
    chk({tag, "_len_m"},    {16'b0, res_len_m}, exp_len);
    chk({tag, "_ok_m"},     {31'b0, res_ok_m}, {31'b0, ok_m});
    chk({tag, "_crc_m"},    res_crc_m, em);
    chk({tag, "_valid_l"},  {31'b0, res_valid_l}, 32'd1);
    chk({tag, "_len_l"},    {16'b0, res_len_l}, exp_len);
    chk({tag, "_ok_l"},     {31'b0, res_ok_l}, {31'b0, ok_l});
    chk({tag, "_crc_l"},    res_crc_l, el);
    @(negedge clk);
    chk({tag, "_strobe1"},  {31'b0, res_valid_m}, 32'd0);
    chk({tag, "_busy_end"}, {31'b0, busy_m}, 32'd0);
    chk({tag, "_crc_hold"}, res_crc_m, em);
    last_em = em; last_el = el; last_len = exp_len;
  endtask

  task automatic run_vec(input int idx, input string tag, input int gap_idx);
    build_frame(vecs[idx]);
    send_bytes(-1, 0, gap_idx);
    wait_result(tag, vecs[idx].exp_len, vecs[idx].exp_ok_m, vecs[idx].exp_ok_l);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    vecs[0] = '{1, 128'hA5, 0, -1, 8'h00, 1,  1'b0, 1'b0};
    vecs[1] = '{9, DIGITS,  1, -1, 8'h00, 13, 1'b1, 1'b0};
    vecs[2] = '{9, DIGITS,  1,  3, 8'h04, 13, 1'b0, 1'b0};
    vecs[3] = '{9, DIGITS,  2, -1, 8'h00, 13, 1'b0, 1'b1};
    vecs[4] = '{0, 128'h0,  1, -1, 8'h00, 4,  1'b1, 1'b0};
    vecs[5] = '{0, 128'h0,  2, -1, 8'h00, 4,  1'b0, 1'b1};
    vecs[6] = '{3, ABC,     0, -1, 8'h00, 3,  1'b0, 1'b0};

    reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_abort = 1'b0;
`ifdef CRC32_FRAME_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready",     {31'b0, s_ready_m},   32'd1);
    chk("rst_busy",      {31'b0, busy_m},      32'd0);
    chk("rst_valid",     {31'b0, res_valid_m}, 32'd0);
    chk("rst_ok",        {31'b0, res_ok_m},    32'd0);
    chk("rst_crc",       res_crc_m,            32'd0);
    chk("rst_len",       {16'b0, res_len_m},   32'd0);
`ifdef CRC32_FRAME_STATS_EN
    chk("rst_good",      {16'b0, good_m},      32'd0);
    chk("rst_bad",       {16'b0, bad_m},       32'd0);
`endif

    // Table of directed frames.
    for (int v = 0; v < 7; v++) begin
      run_vec(v, $sformatf("vec%0d", v), -1);
      repeat (2) @(negedge clk);
    end

    // Idle gap inside a frame must not disturb the remainder.
    run_vec(1, "gap", 4);

    // Abort at byte 6, bit 3: no result, outputs held, then a clean frame.
    build_frame(vecs[1]);
    send_bytes(5, 1, -1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (res_valid_m || res_valid_l) seen++;
      @(negedge clk);
    end
    chk("abort_no_res",    seen, 0);
    chk("abort_busy",      {31'b0, busy_m},    32'd0);
    chk("abort_ready",     {31'b0, s_ready_m}, 32'd1);
    chk("abort_len_hold",  {16'b0, res_len_m}, last_len);
    chk("abort_crc_hold",  res_crc_m,          last_em);
    run_vec(1, "post_abort", -1);

    // Reset pulsed mid-SHIFT after a frame with non-zero results.
    run_vec(0, "pre_reset", -1);
    build_frame(vecs[2]);
    send_bytes(4, 2, -1);
    chk("mid_rst_ready", {31'b0, s_ready_m},   32'd1);
    chk("mid_rst_busy",  {31'b0, busy_m},      32'd0);
    chk("mid_rst_valid", {31'b0, res_valid_m}, 32'd0);
    chk("mid_rst_ok",    {31'b0, res_ok_m},    32'd0);
    chk("mid_rst_crc",   res_crc_m,            32'd0);
    chk("mid_rst_crc_l", res_crc_l,            32'd0);
    chk("mid_rst_len",   {16'b0, res_len_m},   32'd0);
    run_vec(3, "post_reset", -1);

`ifdef CRC32_FRAME_STATS_EN
    stats_clr = 1'b1; @(negedge clk); stats_clr = 1'b0;
    for (int i = 0; i < 3; i++) run_vec(1, "stat_good", -1);
    for (int i = 0; i < 2; i++) run_vec(2, "stat_bad", -1);
    chk("stats_good_m", {16'b0, good_m}, 32'd3);
    chk("stats_bad_m",  {16'b0, bad_m},  32'd2);
    chk("stats_good_l", {16'b0, good_l}, 32'd0);
    chk("stats_bad_l",  {16'b0, bad_l},  32'd5);
    stats_clr = 1'b1; @(negedge clk); stats_clr = 1'b0;
    run_vec(1, "stat_after_clr", -1);
    chk("stats_clr_good_m", {16'b0, good_m}, 32'd1);
    chk("stats_clr_bad_m",  {16'b0, bad_m},  32'd0);
    chk("stats_clr_good_l", {16'b0, good_l}, 32'd0);
    chk("stats_clr_bad_l",  {16'b0, bad_l},  32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
